byte_lane_arbiter: RTL and testbench
====================================

Name: byte_lane_arbiter

Overview:
- Round-robin arbiter that shares the 8-to-32 byte packer between NUM_REQ byte-stream requesters, typically lane FIFOs.
- Grants whole BURST_LEN-byte bursts, so each packed 32-bit word comes from exactly one requester.
- Sits directly upstream of the packer in the clk_4f domain.
- Drives the packer's data_in/valid_in and a lane tag for downstream demux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- BURST_LEN, 4, bytes per grant; equals the packer ratio 32/8.

Ports:
- clk_4f  in  1  single clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  req[i]=1 means requester i holds at least BURST_LEN bytes.
- req_mask  in  NUM_REQ  1 = requester excluded from arbitration; sampled only at grant decisions.
- hold  in  1  1 = start no new burst; a burst in progress still completes.
- data_in  in  NUM_REQ*DATA_W  show-ahead byte of requester i, at bits [i*DATA_W +: DATA_W].
- pop  out  NUM_REQ  one-hot read strobe; the byte on data_in[i] is consumed in the same cycle.
- data_out  out  DATA_W  registered byte to the packer.
- valid_out  out  1  registered valid to the packer.
- lane_id  out  $clog2(NUM_REQ)  owner of the byte on data_out.
- word_done  out  1  one-cycle pulse with the last byte of each burst.

Behaviour:
- Reset (async, reset_L=0):
  - pop=0, data_out=0, valid_out=0, lane_id=0, word_done=0.
  - state=IDLE, beat=0, rr_ptr=NUM_REQ-1, so the first grant goes to requester 0.
- States: IDLE, BURST.
- Eligibility: eligible[i] = req[i] & ~req_mask[i].
- Grant selection:
  - Pick the first eligible index searching from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - On grant, rr_ptr <= granted index.
- IDLE:
  - If ~hold and any eligible: grant g, go to BURST, beat=0, pop[g]=1 this cycle (combinational from state and grant).
  - Otherwise pop=0 and stay in IDLE.
- BURST:
  - pop[g]=1 on every beat 0..BURST_LEN-1.
  - Registered output, latency 1 from pop: data_out <= data_in[g], valid_out <= 1, lane_id <= g.
  - beat increments each cycle.
  - req and req_mask are not sampled mid-burst; the burst never aborts.
- Last beat (beat=BURST_LEN-1):
  - A new grant decision is made in the same cycle.
  - If ~hold and any eligible: grant the next lane, beat=0, stay in BURST. Bytes stay back-to-back with no bubble, which the packer requires for continuous words.
  - Otherwise go to IDLE; valid_out drops to 0 the cycle after the last byte is registered.
- word_done is registered and asserts alongside the data_out byte of beat BURST_LEN-1.
- Single eligible requester: it is re-granted continuously, giving an uninterrupted valid stream.
- Simultaneous requests: strict rotation. A lane granted at decision k has the lowest priority at decision k+1.
- hold asserted mid-burst: no effect until the last beat, then the arbiter goes to IDLE.
- Reset mid-burst:
  - Immediate abort; valid_out=0.
  - The partial word in the packer is discarded because its counter clears when valid drops.
  - Requesters own their FIFO recovery.
- Width rules:
  - beat is $clog2(BURST_LEN) bits.
  - rr_ptr wraps from NUM_REQ-1 to 0; a non-power-of-2 NUM_REQ must wrap explicitly, never by overflow.

Decomposition:
- Shared package holds:
  - localparams BURST_LEN=4 and DATA_W=8;
  - the state encoding IDLE=1'b0, BURST=1'b1;
  - the lane_id width function.
- One sub-module, rr_pick: a combinational round-robin priority selector taking eligible and rr_ptr, returning grant_idx and any_grant. Reused by future lane arbiters.

Test Plan:
- Single lane: req=4'b0001, data_in[0]=AA,BB,CC,DD → pop[0] high 4 cycles, then data_out AA..DD with valid_out=1. Packer yields 32'hAABBCCDD; lane_id=0; word_done on DD.
- All requesting: req=4'b1111 held for 16 cycles → grant order 0,1,2,3 with no valid gaps, lane_id changing every 4 bytes, exactly 4 word_done pulses.
- Mask and hold:
  - req=4'b0110 with req_mask=4'b0010 → only lane 2 is granted.
  - Raising hold during beat 1 → the burst finishes, valid_out=0 after 4 bytes, pop=0 while hold=1.
- Req drop mid-burst: lane 1 deasserts req at beat 2 → the burst still completes all 4 pops, then rotation continues to the next eligible lane.
- Reset mid-burst: reset_L low at beat 2 → valid_out, pop and data_out are 0 immediately. After release with req=4'b1000, the first grant is lane 3, reached by rotation from rr_ptr=3 to 0,1,2,3.
- No eligible requester for 10 cycles → pop=0 and valid_out=0 throughout, with no spurious word_done.

Source files
------------

// File: rtl/byte_lane_arbiter_pkg.sv
// byte_lane_arbiter shared types and constants.
// Burst geometry, FSM encoding and width helper.
package byte_lane_arbiter_pkg;
  localparam int BURST_LEN = 4;
  localparam int DATA_W    = 8;
  localparam int BEAT_W    = $clog2(BURST_LEN);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int lane_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/byte_lane_arbiter_if.sv
// byte_lane_arbiter requester/packer bundle.
// master drives requests; slave is the arbiter.
interface byte_lane_arbiter_if
  import byte_lane_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int LW = lane_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_mask;
  logic                      hold;
  logic [NUM_REQ*DATA_W-1:0] data_in;
  logic [NUM_REQ-1:0]        pop;
  logic [DATA_W-1:0]         data_out;
  logic                      valid_out;
  logic [LW-1:0]             lane_id;
  logic                      word_done;

  modport master (
    output req, req_mask, hold, data_in,
    input  pop, data_out, valid_out,
    input  lane_id, word_done
  );

  modport slave (
    input  req, req_mask, hold, data_in,
    output pop, data_out, valid_out,
    output lane_id, word_done
  );
endinterface

// File: rtl/byte_lane_arbiter_rr_pick.sv
// Round-robin priority selector.
// Searches upward from rr_ptr+1, wrapping explicitly.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] eligible,
  input  logic [W-1:0] rr_ptr,
  output logic [W-1:0] grant_idx,
  output logic         any_grant
);
  int idx;

  // first eligible index after rr_ptr, modulo N
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = 1; k <= N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any_grant && eligible[idx]) begin
        any_grant = 1'b1;
        grant_idx = W'(idx);
      end
    end
  end
endmodule

// File: rtl/byte_lane_arbiter.sv
// Round-robin burst arbiter feeding the 8-to-32 packer.
// Grants whole bursts; output byte registered one cycle after pop.
module byte_lane_arbiter
  import byte_lane_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input logic                 clk_4f,
  input logic                 reset_L,
  byte_lane_arbiter_if.slave  bus
);
  localparam int LW = lane_w(NUM_REQ);
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LW-1:0]     lane_q, lane_d;
  logic [LW-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0] elig;
  logic [LW-1:0]     gidx;
  logic              any;
  logic              pop_en;
  logic              pop_last;
  logic [LW-1:0]     pop_lane;

  assign elig = bus.req & ~bus.req_mask;

  rr_pick #(
    .N (NUM_REQ),
    .W (LW)
  ) u_pick (
    .eligible  (elig),
    .rr_ptr    (rr_q),
    .grant_idx (gidx),
    .any_grant (any)
  );

  // the IDLE grant cycle is beat 0, so BURST resumes at beat 1
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lane_d   = lane_q;
    rr_d     = rr_q;
    pop_en   = 1'b0;
    pop_last = 1'b0;
    pop_lane = lane_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.hold && any) begin
          pop_en   = 1'b1;
          pop_lane = gidx;
          state_d  = BURST;
          beat_d   = BEAT_W'(1);
          lane_d   = gidx;
          rr_d     = gidx;
        end
      end
      BURST: begin
        pop_en = 1'b1;
        if (beat_q == LAST) begin
          pop_last = 1'b1;
          beat_d   = '0;
          if (!bus.hold && any) begin
            lane_d = gidx;
            rr_d   = gidx;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pop = (pop_en && reset_L) ?
                   (NUM_REQ'(1) << pop_lane) : '0;

  // FSM, beat counter and round-robin pointer
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      beat_q  <= '0;
      lane_q  <= '0;
      rr_q    <= LW'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      lane_q  <= lane_d;
      rr_q    <= rr_d;
    end
  end

  // registered byte stream to the packer
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      bus.data_out  <= '0;
      bus.valid_out <= 1'b0;
      bus.lane_id   <= '0;
      bus.word_done <= 1'b0;
    end else if (pop_en) begin
      bus.data_out  <= bus.data_in[pop_lane*DATA_W +: DATA_W];
      bus.valid_out <= 1'b1;
      bus.lane_id   <= pop_lane;
      bus.word_done <= pop_last;
    end else begin
      bus.valid_out <= 1'b0;
      bus.word_done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_byte_lane_arbiter.sv
// byte_lane_arbiter bench: directed scenarios plus
// random traffic against a byte-countdown reference.
module tb_byte_lane_arbiter;
  localparam int N  = 4;
  localparam int BL = 4;

  logic clk_4f = 1'b0;
  logic reset_L = 1'b0;

  byte_lane_arbiter_if #(.NUM_REQ(N)) bus ();

  byte_lane_arbiter #(.NUM_REQ(N)) dut (
    .clk_4f  (clk_4f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  always #5 clk_4f = ~clk_4f;

  int passed = 0;
  int total  = 0;

  logic [7:0] q [N][$];

  int m_left, m_owner, m_last;
  logic [7:0] e_data;
  logic [1:0] e_lane;
  logic       e_valid, e_wd;

  int wd_cnt;
  int pop_cnt [N];
  logic [31:0] word;

  task chk(input string tag, input logic [31:0] obs,
           input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function int pick();
    int idx;
    for (int k = 1; k <= N; k++) begin
      idx = (m_last + k) % N;
      if (bus.req[idx] && !bus.req_mask[idx]) return idx;
    end
    return -1;
  endfunction

  function void decide();
    int g;
    if (bus.hold) return;
    g = pick();
    if (g >= 0) begin
      m_owner = g;
      m_left  = BL;
      m_last  = g;
    end
  endfunction

  function void model_reset();
    m_left  = 0;
    m_owner = 0;
    m_last  = N - 1;
    e_data  = '0;
    e_lane  = '0;
    e_valid = 1'b0;
    e_wd    = 1'b0;
  endfunction

  task clr_stats();
    wd_cnt = 0;
    word   = '0;
    for (int i = 0; i < N; i++) pop_cnt[i] = 0;
  endtask

  // one clock: drive fronts, check at negedge, step model
  task cycle();
    logic [N-1:0] ep;
    logic [7:0] b;
    for (int i = 0; i < N; i++) begin
      while (q[i].size() < 2) q[i].push_back(8'($urandom));
      bus.data_in[i*8 +: 8] = q[i][0];
    end
    @(negedge clk_4f);
    chk("valid_out", 32'(bus.valid_out), 32'(e_valid));
    chk("data_out", 32'(bus.data_out), 32'(e_data));
    chk("lane_id", 32'(bus.lane_id), 32'(e_lane));
    chk("word_done", 32'(bus.word_done), 32'(e_wd));
    if (bus.word_done) wd_cnt++;
    if (bus.valid_out && bus.lane_id == 0)
      word = {word[23:0], bus.data_out};
    for (int i = 0; i < N; i++) if (bus.pop[i]) pop_cnt[i]++;
    ep = '0;
    if (m_left == 0) decide();
    if (m_left > 0) begin
      ep      = N'(1) << m_owner;
      b       = q[m_owner].pop_front();
      e_data  = b;
      e_lane  = 2'(m_owner);
      e_valid = 1'b1;
      e_wd    = (m_left == 1);
      m_left--;
      if (m_left == 0) decide();
    end else begin
      e_valid = 1'b0;
      e_wd    = 1'b0;
    end
    chk("pop", 32'(bus.pop), 32'(ep));
    @(posedge clk_4f);
    #1;
  endtask

  task run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // assert reset mid-cycle, check, release after next edge
  task do_reset();
    reset_L = 1'b0;
    #1;
    chk("rst_pop", 32'(bus.pop), 32'h0);
    chk("rst_valid", 32'(bus.valid_out), 32'h0);
    chk("rst_data", 32'(bus.data_out), 32'h0);
    chk("rst_lane", 32'(bus.lane_id), 32'h0);
    chk("rst_wd", 32'(bus.word_done), 32'h0);
    model_reset();
    @(posedge clk_4f);
    #1;
    reset_L = 1'b1;
  endtask

  initial begin
    bus.req      = '0;
    bus.req_mask = '0;
    bus.hold     = 1'b0;
    bus.data_in  = '0;
    model_reset();
    clr_stats();
    #12;
    do_reset();

    // single lane burst packs AABBCCDD
    q[0].delete();
    q[0].push_back(8'hAA);
    q[0].push_back(8'hBB);
    q[0].push_back(8'hCC);
    q[0].push_back(8'hDD);
    bus.req = 4'b0001;
    cycle();
    bus.req = 4'b0000;
    run(7);
    chk("single_word", word, 32'hAABBCCDD);
    chk("single_pops", 32'(pop_cnt[0]), 32'd4);
    chk("single_wd", 32'(wd_cnt), 32'd1);

    // all lanes, strict rotation from reset
    do_reset();
    clr_stats();
    bus.req = 4'b1111;
    run(15);
    bus.req = 4'b0000;
    run(5);
    chk("all_wd", 32'(wd_cnt), 32'd4);
    for (int i = 0; i < N; i++)
      chk("all_pops", 32'(pop_cnt[i]), 32'd4);

    // mask leaves only lane 2
    clr_stats();
    bus.req      = 4'b0110;
    bus.req_mask = 4'b0010;
    run(10);
    chk("mask_l1", 32'(pop_cnt[1]), 32'd0);
    chk("mask_l2", 32'(pop_cnt[2]), 32'd10);
    bus.req      = '0;
    bus.req_mask = '0;
    run(5);

    // hold raised during beat 1
    clr_stats();
    bus.req = 4'b1111;
    run(2);
    bus.hold = 1'b1;
    run(8);
    chk("hold_wd", 32'(wd_cnt), 32'd1);
    bus.hold = 1'b0;
    bus.req  = '0;
    run(3);

    // requester drops req mid-burst
    bus.req = 4'b0110;
    run(3);
    bus.req = 4'b0100;
    run(10);
    bus.req = '0;
    run(3);

    // reset at beat 2, then lane 3 wins first
    bus.req = 4'b1111;
    run(3);
    do_reset();
    clr_stats();
    bus.req = 4'b1000;
    run(6);
    chk("post_rst_l3", 32'(pop_cnt[3]), 32'd6);
    bus.req = '0;
    run(3);

    // nobody eligible
    clr_stats();
    bus.req      = 4'b0101;
    bus.req_mask = 4'b0101;
    run(10);
    chk("none_wd", 32'(wd_cnt), 32'd0);
    for (int i = 0; i < N; i++)
      chk("none_pops", 32'(pop_cnt[i]), 32'd0);
    bus.req_mask = '0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.req      = 4'($urandom);
      bus.req_mask = ($urandom_range(0, 3) == 0) ?
                     4'($urandom) : 4'b0000;
      bus.hold     = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
